// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } UART_TX_STATE_t;

  localparam logic [1:0] UART_TXDATA_OFS  = 2'd0;
  localparam logic [1:0] UART_STATUS_OFS  = 2'd1;
  localparam logic [1:0] UART_DIVISOR_OFS = 2'd2;

  localparam int UART_ST_BUSY    = 0;
  localparam int UART_ST_EMPTY   = 1;
  localparam int UART_ST_FULL    = 2;
  localparam int UART_ST_OVF     = 3;
  localparam int UART_ST_CNT_LSB = 8;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Core data-bus bundle: the core drives address/strobes, the peripheral returns read data.
interface uart_tx_mmio_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wrdata;
  logic        bus_wren;
  logic        bus_rden;
  logic [31:0] bus_rddata;

  modport master (
    output bus_addr, bus_wrdata, bus_wren, bus_rden,
    input  bus_rddata
  );

  modport slave (
    input  bus_addr, bus_wrdata, bus_wren, bus_rden,
    output bus_rddata
  );
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with combinational head read; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty   = (r_count == '0);
  assign full    = (r_count == CW'(DEPTH));
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_pop   = pop && !empty;
  assign w_push  = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: register decode, TX FIFO and 8N1 baud/shift FSM.
// state | meaning
// IDLE  | line high, waiting for FIFO data
// START | start bit (0) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1); chains straight into START if more data is queued
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           tx_idle_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  UART_TX_STATE_t r_state, w_state_n;
  logic [15:0]    r_div;
  logic           r_ovf;
  logic [15:0]    r_baud_cnt, w_baud_cnt_n;
  logic [2:0]     r_bit_idx, w_bit_idx_n;
  logic [7:0]     r_shift, w_shift_n;
  logic           r_tx, w_tx_n;
  logic           r_irq, w_irq_n;

  logic           w_sel;
  logic [1:0]     w_ofs;
  logic           w_wr_txdata, w_wr_status, w_wr_div;
  logic           w_push, w_pop, w_tick;
  logic [15:0]    w_div_m1;
  logic [7:0]     w_fifo_rd;
  logic           w_empty, w_full;
  logic [CW-1:0]  w_count, w_count_n;
  logic [31:0]    w_status, w_rddata;

  assign w_sel       = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
  assign w_ofs       = bus.bus_addr[3:2];
  assign w_wr_txdata = bus.bus_wren && w_sel && (w_ofs == UART_TXDATA_OFS);
  assign w_wr_status = bus.bus_wren && w_sel && (w_ofs == UART_STATUS_OFS);
  assign w_wr_div    = bus.bus_wren && w_sel && (w_ofs == UART_DIVISOR_OFS);
  assign w_push      = w_wr_txdata && (!w_full || w_pop);
  assign w_count_n   = w_count + CW'(w_push) - CW'(w_pop);

  // A divisor of zero behaves as one clock per bit
  assign w_div_m1 = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
  assign w_tick   = (r_baud_cnt == 16'd0);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data (bus.bus_wrdata[7:0]),
    .rd_data (w_fifo_rd),
    .empty   (w_empty),
    .full    (w_full),
    .count   (w_count)
  );

  always_comb begin
    w_status                         = '0;
    w_status[UART_ST_BUSY]           = (r_state != IDLE);
    w_status[UART_ST_EMPTY]          = w_empty;
    w_status[UART_ST_FULL]           = w_full;
    w_status[UART_ST_OVF]            = r_ovf;
    w_status[UART_ST_CNT_LSB +: CW]  = w_count;
  end

  always_comb begin
    w_rddata = '0;
    if (bus.bus_rden && w_sel) begin
      case (w_ofs)
        UART_STATUS_OFS:  w_rddata = w_status;
        UART_DIVISOR_OFS: w_rddata = {16'd0, r_div};
        default:          w_rddata = '0;
      endcase
    end
  end
  assign bus.bus_rddata = w_rddata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= DIV_RESET;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_div) r_div <= bus.bus_wrdata[15:0];
      if (w_wr_txdata && !w_push)                 r_ovf <= 1'b1;
      else if (w_wr_status && bus.bus_wrdata[3])  r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_bit_idx_n  = r_bit_idx;
    w_shift_n    = r_shift;
    w_pop        = 1'b0;
    w_baud_cnt_n = r_baud_cnt;
    if (r_state != IDLE && !w_tick) w_baud_cnt_n = r_baud_cnt - 16'd1;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_n    = w_fifo_rd;
          w_bit_idx_n  = 3'd0;
          w_baud_cnt_n = w_div_m1;
          w_state_n    = START;
        end
      end
      START: begin
        if (w_tick) begin
          w_baud_cnt_n = w_div_m1;
          w_bit_idx_n  = 3'd0;
          w_state_n    = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_baud_cnt_n = w_div_m1;
          if (r_bit_idx == 3'd7) begin
            w_state_n = STOP;
          end else begin
            w_shift_n   = r_shift >> 1;
            w_bit_idx_n = r_bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_baud_cnt_n = w_div_m1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_n   = w_fifo_rd;
            w_bit_idx_n = 3'd0;
            w_state_n   = START;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase

    // Line level is registered from the next state so it changes on bit boundaries
    case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_shift_n[0];
      default: w_tx_n = 1'b1;
    endcase
    w_irq_n = (w_state_n == IDLE) && (w_count_n == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_irq      <= 1'b1;
    end else begin
      r_state    <= w_state_n;
      r_baud_cnt <= w_baud_cnt_n;
      r_bit_idx  <= w_bit_idx_n;
      r_shift    <= w_shift_n;
      r_tx       <= w_tx_n;
      r_irq      <= w_irq_n;
    end
  end

  assign tx          = r_tx;
  assign tx_idle_irq = r_irq;

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the RV32I core's data bus, directly downstream of the core's `bus_addr`/`bus_wrdata`/`bus_wren`/`bus_rden` outputs; it returns read data on `bus_rddata`. Software writes bytes into an 8-entry TX FIFO. A baud-rate FSM serialises them as 8N1 frames on `tx`. Status and divisor registers are readable over the same bus.

## Interface
- `BASE_ADDR`, 32'h1000_0000: window base; the block is selected when `bus_addr[31:4] == BASE_ADDR[31:4]`.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of 2, at least 2.
- `DIV_RESET`, 16'd434: divisor reset value, in clocks per bit.
- `clk`, input, 1: single clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `bus_addr`, input, 32: core bus address. Word offset is `bus_addr[3:2]`.
- `bus_wrdata`, input, 32: core write data.
- `bus_wren`, input, 1: write strobe, one cycle per access.
- `bus_rden`, input, 1: read strobe.
- `bus_rddata`, output, 32: read data, combinational.
- `tx`, output, 1: serial line. Registered; idles high.
- `tx_idle_irq`, output, 1: registered; high when the FIFO is empty and the FSM is in IDLE.

## Operation
- Register map (word offsets):
  - 0x0 TXDATA (W): pushes `bus_wrdata[7:0]` into the FIFO. Reads return 0.
  - 0x4 STATUS (R, bit 3 W1C):
    - bit 0 busy: FSM not in IDLE.
    - bit 1 empty.
    - bit 2 full.
    - bit 3 overflow: sticky; cleared by writing 1 to bit 3.
    - bits [11:8] count: 0..FIFO_DEPTH.
    - Other bits read as 0.
  - 0x8 DIVISOR (R/W): 16 bits in `[15:0]`; upper bits read as 0 and are ignored on write. A value of 0 is treated as 1.
  - 0xC: reserved. Reads return 0; writes are ignored.
- Bus reads:
  - `bus_rddata` is valid in the same cycle as `bus_rden`; the core samples it at the clock edge.
  - Output is 0 when `bus_rden` is low or the address is outside the window.
  - Reads have no side effects.
- Push rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the write is dropped and overflow is set.
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop into the shift register, load the bit counter, and go to START.
  - START: drives `tx` = 0 for one bit time, then goes to DATA with bit index 0.
  - DATA: drives `shift[0]` (LSB first), shifting each bit time. After bit index 7, go to STOP.
  - STOP: drives `tx` = 1 for one bit time. At the end of STOP: if the FIFO is not empty, pop and go to START (no gap between frames); otherwise go to IDLE.
- Bit time equals DIVISOR clocks. The down-counter reloads DIVISOR−1 at each bit boundary, so a DIVISOR write mid-frame takes effect at the next bit boundary.

## Timing
- Reset values (applied immediately, asynchronously):
  - `tx` = 1, `tx_idle_irq` = 1.
  - FSM in IDLE, FIFO empty with count 0.
  - Overflow 0, DIVISOR = DIV_RESET.
  - `bus_rddata` = 0.
- Reset mid-frame aborts the frame, returns `tx` to 1, and discards FIFO contents.
- Write latency, with FIFO empty and FSM idle:
  - TXDATA write in cycle N.
  - FIFO non-empty in N+1; pop in N+1.
  - `tx` falls at the edge ending N+1.
- Frame length is exactly 10×DIVISOR clocks. Back-to-back frames have zero idle cycles.
- STATUS reflects register state as of the start of the read cycle; a push in the same cycle is not yet visible.
- `tx_idle_irq` deasserts on the edge after the accepted push, and reasserts on the edge the FSM enters IDLE with the FIFO empty.

## Structure
- Shared package `uart_pkg`:
  - `UART_TX_STATE_t` enum (IDLE, START, DATA, STOP).
  - Offset constants `UART_TXDATA_OFS`, `UART_STATUS_OFS`, `UART_DIVISOR_OFS`.
  - STATUS bit-position constants.
- Sub-module `sync_fifo`, parameterised by width and depth:
  - Ports: `push`, `pop`, `wr_data`, `rd_data`, `empty`, `full`, `count`.
  - Read data is available combinationally from the head entry.
- Top level contains the address decode, register file (DIVISOR and overflow), and the TX FSM with baud counter, bit index and shift register.

## Test plan
- Reset, then DIVISOR = 4, write TXDATA 0xA5 → `tx` low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks; total 40 clocks. Falling edge occurs 2 edges after the write.
- Write 9 bytes 0x01–0x09 in consecutive cycles with DIVISOR = 2 → 9 frames in order.
  - The ninth write is accepted because the first pop frees a slot in the same cycle; overflow stays 0.
  - No idle cycles between frames.
- Fill the FIFO while the FSM is stalled mid-frame (DIVISOR = 1000), then write one more byte → byte dropped, STATUS reads 0x0000_0805 (count 8, full, busy) plus bit 3 = 1. Write STATUS with 0x8 → bit 3 clears.
- Read DIVISOR after reset → 0x0000_01B2. Write 0 → line runs at 1 clock per bit. Read offset 0xC and an address outside the window → 0.
- Assert `rst` in the middle of DATA bit 3 → `tx` = 1 immediately, STATUS reads 0x0000_0002, `tx_idle_irq` = 1. A new write transmits cleanly.
- Change DIVISOR from 4 to 8 during a data bit → the current bit keeps 4 clocks and later bits take 8 clocks.
